// File: rtl/sdram_write_combiner_pkg.sv
// sdram_write_combiner_pkg: state encoding and width helpers shared by the write combiner files.
package sdram_write_combiner_pkg;
    typedef enum logic [2:0] {S_EMPTY, S_COLLECT, S_FLUSH, S_READ_REQ, S_READ_WAIT} wc_state_t;
    function automatic int burst_count_width(input int burst_max);
        return $clog2(burst_max) + 1;
    endfunction
endpackage

// File: rtl/sdram_wc_buffer.sv
// sdram_wc_buffer: burst staging array of data+byteenable, written one word per cycle, read asynchronously.
module sdram_wc_buffer #(
    parameter int DATA_W = 16,
    parameter int BE_W = 2,
    parameter int DEPTH = 64,
    parameter int IW = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IW-1:0]     wr_idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   wbe,
    input  logic [IW-1:0]     rd_idx,
    output logic [DATA_W-1:0] rdata,
    output logic [BE_W-1:0]   rbe
);
    logic [DATA_W+BE_W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[wr_idx] <= {wdata, wbe};
    assign {rdata, rbe} = mem[rd_idx];
endmodule

// File: rtl/sdram_write_combiner.sv
// sdram_write_combiner: coalesces sequential single-word CPU writes into dbus bursts;
// reads flush pending writes first so a read always sees earlier writes.
module sdram_write_combiner
    import sdram_write_combiner_pkg::*;
#(
    parameter int WORD_WIDTH = 1,
    parameter int COL_WIDTH = 9,
    parameter int BANK_WIDTH = 2,
    parameter int ROW_WIDTH = 13,
    parameter int BURST_MAX = 64,
    parameter int FLUSH_TIMEOUT = 16,
    localparam int BYTE_AMOUNT = 2 ** WORD_WIDTH,
    localparam int ADDR_WIDTH = WORD_WIDTH + COL_WIDTH + BANK_WIDTH + ROW_WIDTH,
    localparam int DW = 8 * BYTE_AMOUNT,
    localparam int BCW = burst_count_width(BURST_MAX)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init_done,
    input  logic [ADDR_WIDTH-1:0]  cpu_address,
    input  logic                   cpu_read,
    input  logic                   cpu_write,
    input  logic [DW-1:0]          cpu_writedata,
    input  logic [BYTE_AMOUNT-1:0] cpu_byteenable,
    output logic                   cpu_waitrequest,
    output logic [DW-1:0]          cpu_readdata,
    output logic                   cpu_readdatavalid,
    output logic [ADDR_WIDTH-1:0]  dbus_address,
    output logic [BCW-1:0]         dbus_burstcount,
    output logic                   dbus_read,
    output logic                   dbus_write,
    output logic [DW-1:0]          dbus_writedata,
    output logic [BYTE_AMOUNT-1:0] dbus_byteenable,
    input  logic                   dbus_waitrequest,
    input  logic [DW-1:0]          dbus_readdata,
    input  logic                   dbus_readdatavalid
);
    localparam int IW = $clog2(BURST_MAX);
    localparam int CSW = COL_WIDTH + BCW;
    localparam int TW = $clog2(FLUSH_TIMEOUT) + 1;
    wc_state_t state;
    logic [ADDR_WIDTH-1:0] base, raddr;
    logic [BCW-1:0] count, rd_ptr;
    logic [TW-1:0] idle_cnt;
    logic [CSW-1:0] col_end;
    logic req, append_ok, accept, last_word;
    assign req = cpu_read || cpu_write;
    // a burst must stay inside one row, so the column of the next word must not wrap
    assign col_end = CSW'(base[WORD_WIDTH +: COL_WIDTH]) + CSW'(count);
    assign append_ok = state == S_COLLECT && cpu_write && !cpu_read
        && cpu_address == base + (ADDR_WIDTH'(count) << WORD_WIDTH)
        && count < BCW'(BURST_MAX) && col_end < CSW'(2 ** COL_WIDTH);
    assign accept = rst && init_done && (state == S_EMPTY ? req : append_ok);
    assign cpu_waitrequest = !accept;
    assign last_word = rd_ptr == count - 1'b1;
    assign dbus_address = state == S_READ_REQ ? raddr : base;
    assign dbus_burstcount = state == S_READ_REQ ? BCW'(1) : count;
    sdram_wc_buffer #(.DATA_W(DW), .BE_W(BYTE_AMOUNT), .DEPTH(BURST_MAX), .IW(IW)) u_buf (
        .clk(clk),
        .we(accept && !cpu_read),
        .wr_idx(state == S_EMPTY ? '0 : count[IW-1:0]),
        .wdata(cpu_writedata),
        .wbe(cpu_byteenable),
        .rd_idx(rd_ptr[IW-1:0]),
        .rdata(dbus_writedata),
        .rbe(dbus_byteenable)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_EMPTY;
            base <= '0;
            raddr <= '0;
            count <= '0;
            rd_ptr <= '0;
            idle_cnt <= '0;
            dbus_read <= 1'b0;
            dbus_write <= 1'b0;
            cpu_readdata <= '0;
            cpu_readdatavalid <= 1'b0;
        end else begin
            cpu_readdatavalid <= 1'b0;
            case (state)
                S_EMPTY: begin
                    if (accept && cpu_read) begin
                        raddr <= cpu_address;
                        dbus_read <= 1'b1;
                        state <= S_READ_REQ;
                    end else if (accept) begin
                        base <= cpu_address;
                        count <= BCW'(1);
                        idle_cnt <= '0;
                        state <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (accept) begin
                        count <= count + 1'b1;
                        idle_cnt <= '0;
                        // filling the last slot starts the flush right away
                        if (count == BCW'(BURST_MAX - 1)) begin
                            dbus_write <= 1'b1;
                            state <= S_FLUSH;
                        end
                    end else if (req || count == BCW'(BURST_MAX) || idle_cnt == TW'(FLUSH_TIMEOUT - 1)) begin
                        idle_cnt <= '0;
                        dbus_write <= 1'b1;
                        state <= S_FLUSH;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (!dbus_waitrequest) begin
                        rd_ptr <= last_word ? '0 : rd_ptr + 1'b1;
                        count <= last_word ? '0 : count;
                        dbus_write <= !last_word;
                        state <= last_word ? S_EMPTY : S_FLUSH;
                    end
                end
                S_READ_REQ: begin
                    if (!dbus_waitrequest || dbus_readdatavalid) begin
                        dbus_read <= 1'b0;
                        state <= dbus_readdatavalid ? S_EMPTY : S_READ_WAIT;
                        if (dbus_readdatavalid) begin
                            cpu_readdata <= dbus_readdata;
                            cpu_readdatavalid <= 1'b1;
                        end
                    end
                end
                S_READ_WAIT: begin
                    if (dbus_readdatavalid) begin
                        cpu_readdata <= dbus_readdata;
                        cpu_readdatavalid <= 1'b1;
                        state <= S_EMPTY;
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_write_combiner.sv
// tb_sdram_write_combiner: directed scenarios plus randomized traffic against a byte-level memory model.
module tb_sdram_write_combiner;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int BW = 2;
    localparam int BCW = 7;
    localparam int FT = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic init_done = 1'b0;
    logic [AW-1:0] cpu_address = '0;
    logic cpu_read = 1'b0;
    logic cpu_write = 1'b0;
    logic [DW-1:0] cpu_writedata = '0;
    logic [BW-1:0] cpu_byteenable = '0;
    logic cpu_waitrequest;
    logic [DW-1:0] cpu_readdata;
    logic cpu_readdatavalid;
    logic [AW-1:0] dbus_address;
    logic [BCW-1:0] dbus_burstcount;
    logic dbus_read, dbus_write;
    logic [DW-1:0] dbus_writedata;
    logic [BW-1:0] dbus_byteenable;
    logic dbus_waitrequest = 1'b0;
    logic [DW-1:0] dbus_readdata = '0;
    logic dbus_readdatavalid = 1'b0;

    int checks = 0;
    int errors = 0;
    bit stall_en = 1'b0;
    logic [7:0] sdram [int];
    logic [7:0] ref_mem [int];
    int burst_addr [$];
    int burst_cnt [$];
    logic [DW-1:0] word_log [$];
    logic [BW-1:0] be_log [$];
    int wr_idx = 0;
    int write_cycles = 0;
    int dbus_reads = 0;
    int words_at_read = -1;
    bit rd_pending = 1'b0;
    int rd_lat = 0;
    logic [AW-1:0] rd_addr = '0;

    sdram_write_combiner dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
        .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
        .cpu_readdatavalid(cpu_readdatavalid),
        .dbus_address(dbus_address), .dbus_burstcount(dbus_burstcount),
        .dbus_read(dbus_read), .dbus_write(dbus_write),
        .dbus_writedata(dbus_writedata), .dbus_byteenable(dbus_byteenable),
        .dbus_waitrequest(dbus_waitrequest), .dbus_readdata(dbus_readdata),
        .dbus_readdatavalid(dbus_readdatavalid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [DW-1:0] sd_word(input int a);
        return {sdram.exists(a + 1) ? sdram[a + 1] : 8'h00, sdram.exists(a) ? sdram[a] : 8'h00};
    endfunction

    function automatic logic [DW-1:0] ref_word(input int a);
        return {ref_mem.exists(a + 1) ? ref_mem[a + 1] : 8'h00, ref_mem.exists(a) ? ref_mem[a] : 8'h00};
    endfunction

    // controller model: inputs change on the falling edge, transfers complete on the next rising edge
    always @(negedge clk) begin
        dbus_readdatavalid = 1'b0;
        if (!rst) begin
            wr_idx = 0;
            rd_pending = 1'b0;
            dbus_waitrequest = 1'b0;
        end else begin
            if (rd_pending) begin
                if (rd_lat == 0) begin
                    dbus_readdatavalid = 1'b1;
                    dbus_readdata = sd_word(int'(rd_addr));
                    rd_pending = 1'b0;
                end else rd_lat--;
            end
            dbus_waitrequest = stall_en && ($urandom_range(0, 3) == 0);
            if (dbus_write) write_cycles++;
            if (dbus_write && !dbus_waitrequest) begin
                if (wr_idx == 0) begin
                    burst_addr.push_back(int'(dbus_address));
                    burst_cnt.push_back(int'(dbus_burstcount));
                end
                word_log.push_back(dbus_writedata);
                be_log.push_back(dbus_byteenable);
                for (int b = 0; b < BW; b++)
                    if (dbus_byteenable[b]) sdram[int'(dbus_address) + wr_idx * 2 + b] = dbus_writedata[8*b +: 8];
                wr_idx++;
                if (wr_idx >= int'(dbus_burstcount)) wr_idx = 0;
            end
            if (dbus_read && !dbus_waitrequest && !rd_pending) begin
                rd_pending = 1'b1;
                rd_addr = dbus_address;
                rd_lat = $urandom_range(0, 3);
                dbus_reads++;
                words_at_read = word_log.size();
            end
        end
    end

    task automatic clear_logs();
        burst_addr.delete();
        burst_cnt.delete();
        word_log.delete();
        be_log.delete();
        write_cycles = 0;
        dbus_reads = 0;
        words_at_read = -1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be, output int waited);
        @(negedge clk);
        cpu_address = a;
        cpu_writedata = d;
        cpu_byteenable = be;
        cpu_write = 1'b1;
        waited = 0;
        #1;
        while (cpu_waitrequest && waited < 500) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checks++;
        if (cpu_waitrequest) begin
            errors++;
            $display("FAIL write_accept addr=%h waitrequest=%b after %0d cycles, required 0", a, cpu_waitrequest, waited);
        end
        @(posedge clk);
        #1;
        cpu_write = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int pulses);
        int n;
        n = 0;
        @(negedge clk);
        cpu_address = a;
        cpu_read = 1'b1;
        #1;
        while (cpu_waitrequest && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (cpu_waitrequest) begin
            errors++;
            $display("FAIL read_accept addr=%h waitrequest=%b after %0d cycles, required 0", a, cpu_waitrequest, n);
        end
        @(posedge clk);
        #1;
        cpu_read = 1'b0;
        n = 0;
        pulses = 0;
        d = 'x;
        while (!cpu_readdatavalid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (cpu_readdatavalid) begin
            d = cpu_readdata;
            pulses = 1;
            repeat (3) begin
                @(negedge clk);
                if (cpu_readdatavalid) pulses++;
            end
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        repeat (FT + 4) @(negedge clk);
        while ((dbus_write || dbus_read || rd_pending) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (dbus_write || dbus_read) begin
            errors++;
            $display("FAIL drain dbus_write=%b dbus_read=%b, required both 0", dbus_write, dbus_read);
        end
    endtask

    task automatic check_burst(input string name, input int idx, input int addr, input int cnt);
        checks++;
        if (burst_addr.size() <= idx || burst_addr[idx] != addr || burst_cnt[idx] != cnt) begin
            errors++;
            $display("FAIL %s burst%0d got %0d bursts addr=%h cnt=%0d, required addr=%h cnt=%0d", name, idx,
                     burst_addr.size(), burst_addr.size() > idx ? burst_addr[idx] : -1,
                     burst_cnt.size() > idx ? burst_cnt[idx] : -1, addr, cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        init_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cpu_waitrequest, dbus_write, dbus_read, cpu_readdatavalid} !== 4'b1000 || cpu_readdata !== '0) begin
            errors++;
            $display("FAIL reset_values wr=%b dw=%b dr=%b rv=%b rd=%h, required 1 0 0 0 0000",
                     cpu_waitrequest, dbus_write, dbus_read, cpu_readdatavalid, cpu_readdata);
        end
        rst = 1'b1;
        cpu_address = 25'h40;
        cpu_write = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (cpu_waitrequest !== 1'b1) begin
                errors++;
                $display("FAIL no_init_accept waitrequest=%b, required 1", cpu_waitrequest);
            end
        end
        cpu_write = 1'b0;
        init_done = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_idle_flush();
        logic [DW-1:0] d [4];
        int w, n;
        clear_logs();
        stall_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d[i] = DW'($urandom);
            do_write(AW'(32'h100 + 2 * i), d[i], 2'b11, w);
        end
        n = 0;
        @(negedge clk);
        while (!dbus_write && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != FT) begin
            errors++;
            $display("FAIL idle_timeout flush after %0d idle cycles, required %0d", n, FT);
        end
        while (dbus_write && n < 300) begin
            n++;
            @(negedge clk);
        end
        check_burst("idle_flush", 0, 32'h100, 4);
        checks++;
        if (write_cycles != 4 || burst_addr.size() != 1) begin
            errors++;
            $display("FAIL idle_flush_gapless write_cycles=%0d bursts=%0d, required 4 and 1", write_cycles, burst_addr.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (word_log.size() <= i || word_log[i] !== d[i] || be_log[i] !== 2'b11) begin
                errors++;
                $display("FAIL idle_flush_data word%0d got %h be %b, required %h be 11", i,
                         word_log.size() > i ? word_log[i] : 16'hxxxx, be_log.size() > i ? be_log[i] : 2'bxx, d[i]);
            end
        end
    endtask

    task automatic test_full_burst();
        logic [DW-1:0] d [64];
        int w, bad;
        clear_logs();
        stall_en = 1'b0;
        for (int i = 0; i < 64; i++) begin
            d[i] = DW'($urandom);
            do_write(AW'(2 * i), d[i], 2'b11, w);
        end
        @(negedge clk);
        checks++;
        if (dbus_write !== 1'b1 || dbus_burstcount !== 7'd64) begin
            errors++;
            $display("FAIL full_flush_start dbus_write=%b burstcount=%0d, required 1 and 64", dbus_write, dbus_burstcount);
        end
        do_write(AW'(32'h80), 16'h1234, 2'b11, w);
        checks++;
        if (w != 63) begin
            errors++;
            $display("FAIL write65_stall waited %0d cycles, required 63", w);
        end
        check_burst("full_burst", 0, 0, 64);
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (word_log.size() <= i || word_log[i] !== d[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_burst_data %0d words wrong, required 0", bad);
        end
        drain();
    endtask

    task automatic test_nonseq();
        logic [DW-1:0] d1, d2;
        int w;
        clear_logs();
        d1 = DW'($urandom);
        d2 = DW'($urandom);
        do_write(AW'(32'h200), d1, 2'b11, w);
        do_write(AW'(32'h400), d2, 2'b01, w);
        checks++;
        if (w != 2) begin
            errors++;
            $display("FAIL nonseq_stall waited %0d cycles, required 2", w);
        end
        drain();
        check_burst("nonseq", 0, 32'h200, 1);
        check_burst("nonseq", 1, 32'h400, 1);
        checks++;
        if (word_log.size() != 2 || word_log[1] !== d2 || be_log[1] !== 2'b01) begin
            errors++;
            $display("FAIL nonseq_data got %0d words, second %h be %b, required 2 words, %h be 01",
                     word_log.size(), word_log.size() > 1 ? word_log[1] : 16'hxxxx, be_log.size() > 1 ? be_log[1] : 2'bxx, d2);
        end
    endtask

    task automatic test_read_after_write();
        logic [DW-1:0] d;
        int w, p;
        clear_logs();
        stall_en = 1'b1;
        do_write(AW'(32'h10), 16'hBEEF, 2'b11, w);
        do_read(AW'(32'h10), d, p);
        checks++;
        if (d !== 16'hBEEF || p != 1) begin
            errors++;
            $display("FAIL raw_data readdata=%h pulses=%0d, required BEEF and 1", d, p);
        end
        checks++;
        if (dbus_reads != 1 || words_at_read != 1) begin
            errors++;
            $display("FAIL raw_order dbus_reads=%0d words_before_read=%0d, required 1 and 1", dbus_reads, words_at_read);
        end
        check_burst("raw", 0, 32'h10, 1);
        stall_en = 1'b0;
        drain();
    endtask

    task automatic test_row_end();
        int w;
        clear_logs();
        do_write(AW'(32'h3FC), 16'hA510, 2'b11, w);
        do_write(AW'(32'h3FE), 16'hA511, 2'b11, w);
        do_write(AW'(32'h400), 16'hB000, 2'b11, w);
        checks++;
        if (w != 3) begin
            errors++;
            $display("FAIL row_end_stall waited %0d cycles, required 3", w);
        end
        drain();
        check_burst("row_end", 0, 32'h3FC, 2);
        check_burst("row_end", 1, 32'h400, 1);
    endtask

    task automatic test_reset_mid_flush();
        logic [DW-1:0] d;
        int w, k;
        clear_logs();
        for (int i = 0; i < 8; i++) do_write(AW'(32'h1000 + 2 * i), DW'($urandom), 2'b11, w);
        k = 0;
        while (wr_idx < 3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        #2;
        rst = 1'b0;
        cpu_address = AW'(32'h1800);
        cpu_write = 1'b1;
        #1;
        checks++;
        if (dbus_write !== 1'b0 || cpu_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_flush dbus_write=%b waitrequest=%b, required 0 and 1", dbus_write, cpu_waitrequest);
        end
        @(negedge clk);
        checks++;
        if (dbus_write !== 1'b0 || cpu_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold dbus_write=%b waitrequest=%b, required 0 and 1", dbus_write, cpu_waitrequest);
        end
        #2;
        rst = 1'b1;
        init_done = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (cpu_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_no_init waitrequest=%b, required 1", cpu_waitrequest);
        end
        init_done = 1'b1;
        #1;
        checks++;
        if (cpu_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_empty waitrequest=%b, required 0", cpu_waitrequest);
        end
        cpu_write = 1'b0;
        clear_logs();
        d = DW'($urandom);
        do_write(AW'(32'h1800), d, 2'b11, w);
        checks++;
        if (w != 0) begin
            errors++;
            $display("FAIL post_reset_accept waited %0d cycles, required 0", w);
        end
        drain();
        check_burst("post_reset", 0, 32'h1800, 1);
        checks++;
        if (burst_addr.size() != 1 || word_log.size() != 1 || word_log[0] !== d) begin
            errors++;
            $display("FAIL post_reset_data bursts=%0d words=%0d, required 1 burst of %h", burst_addr.size(), word_log.size(), d);
        end
    endtask

    task automatic test_random();
        int cur, a, w, p, r, bad, col;
        logic [DW-1:0] d, got;
        logic [BW-1:0] be;
        clear_logs();
        stall_en = 1'b1;
        cur = 32'h8000;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                a = ($urandom_range(0, 9) < 8) ? cur : 32'h8000 + 2 * $urandom_range(0, 1023);
                d = DW'($urandom);
                be = BW'($urandom_range(1, 3));
                do_write(AW'(a), d, be, w);
                for (int b = 0; b < BW; b++)
                    if (be[b]) ref_mem[a + b] = d[8*b +: 8];
                cur = (a + 2 >= 32'h8800) ? 32'h8000 : a + 2;
            end else if (r <= 7) begin
                a = cur - 2 * $urandom_range(1, 8);
                if (a < 32'h8000) a = 32'h8000;
                do_read(AW'(a), got, p);
                checks++;
                if (got !== ref_word(a) || p != 1) begin
                    errors++;
                    $display("FAIL random_read addr=%h got %h pulses=%0d, required %h and 1", a, got, p, ref_word(a));
                end
            end else begin
                repeat ($urandom_range(1, 20)) @(negedge clk);
            end
        end
        drain();
        bad = 0;
        for (int i = 0; i < burst_addr.size(); i++) begin
            col = (burst_addr[i] >> 1) % 512;
            if (burst_cnt[i] < 1 || burst_cnt[i] > 64 || col + burst_cnt[i] > 512) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL random_burst_shape %0d illegal bursts, required 0", bad);
        end
        bad = 0;
        foreach (ref_mem[k])
            if (!sdram.exists(k) || sdram[k] !== ref_mem[k]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL random_memory %0d bytes differ from model, required 0", bad);
        end
        stall_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_flush();
        test_full_burst();
        test_nonseq();
        test_read_after_write();
        test_row_end();
        test_reset_mid_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
